// File: rtl/ex_mem_reg_if.sv
// Memory-stage bus between the EX/MEM register (master) and the cache memory stage (slave).
// The master drives the address, store data and the Rd/Wr/createdump strobes; the slave answers with Done and Stall.
interface ex_mem_reg_if;
    logic [15:0] mem_alu_result;
    logic [15:0] mem_write_data;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_createdump;
    logic        mem_done;
    logic        mem_stall;

    modport master (
        output mem_alu_result, mem_write_data, mem_rd, mem_wr, mem_createdump,
        input  mem_done, mem_stall
    );

    modport slave (
        input  mem_alu_result, mem_write_data, mem_rd, mem_wr, mem_createdump,
        output mem_done, mem_stall
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a one-request-per-instruction memory sequencer.
// It holds the front of the pipe while a miss is outstanding and raises a sticky err on protocol violations.
module ex_mem_reg #(
    parameter int TIMEOUT = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ex_valid,
    input  logic         ex_flush,
    input  logic [15:0]  ex_alu_result,
    input  logic [15:0]  ex_write_data,
    input  logic         ex_mem_read,
    input  logic         ex_mem_write,
    input  logic         ex_reg_write,
    input  logic [2:0]   ex_write_reg,
    input  logic         ex_halt,
    ex_mem_reg_if.master mem,
    output logic         mem_reg_write,
    output logic [2:0]   mem_write_reg,
    output logic         mem_valid,
    output logic         wb_advance,
    output logic         pipe_stall,
    output logic         err
);
    localparam logic [4:0] TMO = 5'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] alu_q, alu_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        rw_q, rw_d;
    logic        halt_q, halt_d;
    logic        valid_q, valid_d;
    logic [2:0]  wreg_q, wreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic stall;
    logic in_valid;
    logic both_err;
    logic new_op;
    logic unused_mem_stall;

    // mem_stall carries no control meaning here; Done alone ends a request.
    assign unused_mem_stall = mem.mem_stall;

    always_comb begin
        stall    = (state_q != IDLE) && !mem.mem_done;
        in_valid = ex_valid && !ex_flush;
        both_err = !stall && in_valid && ex_mem_read && ex_mem_write;
        new_op   = !stall && in_valid && (ex_mem_read ^ ex_mem_write);
    end

    // Pipeline register: load on every unstalled edge, bubble when the entry is not a legal instruction.
    always_comb begin
        alu_d   = alu_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rw_d    = rw_q;
        halt_d  = halt_q;
        valid_d = valid_q;
        wreg_d  = wreg_q;
        if (!stall) begin
            if (in_valid && !both_err) begin
                alu_d   = ex_alu_result;
                wdata_d = ex_write_data;
                rd_d    = ex_mem_read;
                wr_d    = ex_mem_write;
                rw_d    = ex_reg_write;
                halt_d  = ex_halt;
                valid_d = 1'b1;
                wreg_d  = ex_write_reg;
            end else begin
                alu_d   = '0;
                wdata_d = '0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                rw_d    = 1'b0;
                halt_d  = 1'b0;
                valid_d = 1'b0;
                wreg_d  = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (new_op) state_d = REQ;
            REQ, WAIT: begin
                if (mem.mem_done) state_d = new_op ? REQ : IDLE;
                else              state_d = WAIT;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d == REQ)
            cnt_d = '0;
        else if (state_q == WAIT && cnt_q != TMO)
            cnt_d = cnt_q + 5'd1;
        err_d = err_q || both_err || (state_q == IDLE && mem.mem_done) || (cnt_d == TMO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            alu_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rw_q    <= 1'b0;
            halt_q  <= 1'b0;
            valid_q <= 1'b0;
            wreg_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rw_q    <= rw_d;
            halt_q  <= halt_d;
            valid_q <= valid_d;
            wreg_q  <= wreg_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem.mem_alu_result = alu_q;
    assign mem.mem_write_data = wdata_q;
    assign mem.mem_rd         = (state_q == REQ) && rd_q;
    assign mem.mem_wr         = (state_q == REQ) && wr_q;
    assign mem.mem_createdump = valid_q && halt_q;
    assign mem_reg_write      = rw_q;
    assign mem_write_reg      = wreg_q;
    assign mem_valid          = valid_q;
    assign pipe_stall         = stall;
    assign wb_advance         = valid_q && !stall;
    assign err                = err_q;
endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register and memory-request sequencer, directly upstream of the memory stage.
- Latches EX results, drives the cache memory system's Addr/DataIn/Rd/Wr/createdump through the memory stage, and sequences one request per instruction.
- Holds the pipeline while a miss is outstanding, and flags protocol errors.

Parameters:
- TIMEOUT, 31: maximum cycles in WAIT before err is set (5-bit counter).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- ex_valid  input  1  EX holds a valid instruction
- ex_flush  input  1  replace the incoming EX instruction with a bubble
- ex_alu_result  input  16  address / ALU result
- ex_write_data  input  16  store data
- ex_mem_read  input  1  load
- ex_mem_write  input  1  store
- ex_reg_write  input  1  writes the register file
- ex_write_reg  input  3  destination register
- ex_halt  input  1  HALT instruction
- mem_done  input  1  Done from the memory stage
- mem_stall  input  1  Stall from the memory stage
- mem_alu_result  output  16  to memory-stage ALU_result
- mem_write_data  output  16  to memory-stage read_data_in (store data)
- mem_rd  output  1  MemRead to the memory stage
- mem_wr  output  1  MemWrite to the memory stage
- mem_createdump  output  1  createdump to the memory stage
- mem_reg_write  output  1  registered control, forwarded to MEM/WB
- mem_write_reg  output  3  registered control, forwarded to MEM/WB
- mem_valid  output  1  the register holds a valid instruction
- wb_advance  output  1  instruction completes MEM this cycle
- pipe_stall  output  1  freeze IF/ID/EX
- err  output  1  sticky error

Behaviour:
- Reset (asynchronous, active-high):
  - All data and control registers are 0; state IDLE; wait counter 0.
  - err, mem_rd, mem_wr, pipe_stall and wb_advance are all 0.
  - Reset mid-request abandons the request; no retry after reset.
- Capture rule: on each rising edge where pipe_stall is 0, the register loads the EX inputs.
  - If ex_flush is 1 or ex_valid is 0, it loads a bubble instead: mem_valid=0 and all control bits 0; data fields are don't-care but loaded as 0.
  - When pipe_stall is 1, every register holds.
- FSM states: IDLE, REQ, WAIT.
  - IDLE to REQ on a capture of a valid instruction with exactly one of mem_read/mem_write set.
  - Any other capture stays in IDLE.
  - REQ: mem_rd/mem_wr follow the latched op for this single cycle.
    - If mem_done=1 in this cycle (hit), the op completes. Next state is REQ when a new memory op is captured at this edge, otherwise IDLE.
    - If mem_done=0, next state is WAIT.
  - WAIT: mem_rd=mem_wr=0 and the counter increments each cycle.
    - If mem_done=1, the op completes and the next state is chosen as from REQ.
    - If mem_done=0, stay in WAIT.
- pipe_stall = (state==REQ or WAIT) and !mem_done.
- wb_advance = mem_valid and !pipe_stall.
- Latency:
  - A non-memory op or a hit spends 1 cycle in MEM.
  - A miss spends 1 + N cycles, where N = cycles until Done.
- mem_rd/mem_wr are single-cycle pulses per instruction. They are never re-asserted while in WAIT, even if mem_stall toggles.
- mem_createdump = mem_valid and latched halt, held for as long as the entry is held.
- Flush while an op is in REQ/WAIT: ex_flush affects only the incoming EX entry. The latched memory op always runs to completion and cannot be cancelled.
- Error conditions set err, which stays 1 until reset:
  - A captured valid instruction with both ex_mem_read and ex_mem_write set. That entry is converted to a bubble and no request is issued.
  - The wait counter reaching TIMEOUT.
  - mem_done=1 while in IDLE.
- The wait counter clears on every entry to REQ. It saturates at TIMEOUT and never wraps.
- mem_stall is otherwise informational and does not gate any state transition.

Test Plan:
- Reset, then an ALU op is captured (ex_valid=1, ex_alu_result=0x1234, ex_reg_write=1, ex_write_reg=5) -> next cycle: mem_alu_result=0x1234, mem_write_reg=5, wb_advance=1, pipe_stall=0, mem_rd=0.
- Load to 0x0040 with mem_done=1 in the REQ cycle (hit) -> mem_rd high for exactly 1 cycle, pipe_stall never asserted, a following instruction is captured on the next edge.
- Store of 0xBEEF to 0x0080 with mem_done arriving 4 cycles after the request -> mem_wr pulses for 1 cycle and pipe_stall is high for 4 cycles. During the stall mem_alu_result/mem_write_data stay 0x0080/0xBEEF and EX changes are ignored. wb_advance=1 in the mem_done cycle.
- ex_flush asserted during the miss above -> the store still completes, and the entry captured after the stall is a bubble (mem_valid=0).
- A valid instruction with ex_mem_read=ex_mem_write=1 -> err=1 sticky, no mem_rd/mem_wr pulse, entry is a bubble. err clears only on rst.
- Load with mem_done held low for 31 cycles -> err rises on reaching TIMEOUT. Asserting rst mid-WAIT returns state to IDLE and drops pipe_stall and err immediately.
